sync_up_counter_mod: RTL and testbench
======================================

Name: sync_up_counter_mod

Overview:
- Fully synchronous modulo-N up counter; the counting-up counterpart to the team's asynchronous ripple down counter.
- All flops share one clock, so there is no ripple skew on q.
- Provides enable, synchronous clear, parallel load, a cascadable terminal-count output and a sticky overflow flag.
- Used as the up-counting timebase / event counter alongside the down-counting blocks.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count sequence is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration must fail outside it.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-low reset, sampled on posedge clk.
- en  input  1  count enable; counter advances by 1 on a clock edge with en=1.
- clr  input  1  synchronous clear of count and overflow flag.
- load  input  1  synchronous parallel load of d.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count: combinational, (q == MODULUS-1) && en. Used for cascading into the next stage's en.
- ovf  output  1  sticky overflow: set on wrap, cleared by clr or rst (registered).
- load_err  output  1  one-cycle registered pulse when a load value is out of range.

Behaviour:
- Reset: rst=0 at posedge clk gives q=0, ovf=0, load_err=0.
  - rst has absolute priority over clr, load and en.
  - tc is 0 whenever q != MODULUS-1 or en=0.
- Priority each edge with rst=1: clr > load > en > hold.
  - clr=1: q <= 0, ovf <= 0, load_err <= 0. load and en are ignored.
  - load=1 and d <= MODULUS-1: q <= d, load_err <= 0, ovf unchanged. en is ignored that cycle (no increment of the loaded value).
  - load=1 and d >= MODULUS: q <= MODULUS-1 (saturate), load_err <= 1 for exactly one cycle, ovf unchanged.
  - en=1 and q < MODULUS-1: q <= q+1.
  - en=1 and q == MODULUS-1: q <= 0, ovf <= 1. This is the wrap.
  - Otherwise q holds.
- load_err behaviour:
  - Cleared on every edge where no erroneous load occurs.
  - Back-to-back erroneous loads hold it high.
- Latency:
  - q and ovf reflect control inputs one clock after the sampling edge.
  - tc is same-cycle combinational from q and en, so cascaded stages advance on the same edge as the wrapping stage.
- Arithmetic:
  - Unsigned; the increment is computed at WIDTH bits.
  - When MODULUS == 2**WIDTH the wrap is the natural rollover, and the same ovf/tc rules apply.
- Simultaneous events:
  - clr with wrap: the clear wins and ovf ends at 0.
  - load at q == MODULUS-1 with en=1: the load wins, no wrap, ovf unchanged, and tc is still asserted that cycle (tc ignores load).
- Reset mid-count: the next edge forces all registers to reset values regardless of the other inputs. Counting resumes from 0 on the first edge after rst returns to 1 with en=1.
- No internal clock gating and no derived clocks: every flop is on clk.

Test Plan:
- Reset then count (WIDTH=4, MODULUS=10):
  - Stimulus: rst=0 for 2 cycles, then rst=1, en=1 for 12 cycles.
  - Required: q = 0,1,...,9,0,1. tc=1 only while q=9. ovf rises on the edge where q goes 9 to 0 and stays 1.
- Hold and clear:
  - Stimulus: from q=5, en=0 for 3 cycles, then clr=1 with en=1 for one cycle.
  - Required: q stays 5, then becomes 0, and ovf becomes 0.
- Load legal and illegal (MODULUS=10):
  - Stimulus: load=1, d=7 with en=1; then load=1, d=12.
  - Required: q=7 with load_err=0; then q=9 with load_err=1 for exactly one cycle. Next edge with en=1: q=0, ovf=1.
- Priority collisions:
  - Stimulus: at q=9 with en=1, apply clr=1, load=1, d=3.
  - Required: q=0 and ovf=0. Repeat with clr=0: q=3, ovf unchanged.
- Reset mid-operation:
  - Stimulus: while counting at q=6 with ovf=1, pulse rst=0 for one edge, holding load=1 and clr=0.
  - Required: q=0 and ovf=0; the load is ignored.
- Full-range cascade (WIDTH=4, MODULUS=16, two instances):
  - Stimulus: stage B en driven by stage A tc; run 256 cycles with stage A en=1.
  - Required: {B.q, A.q} counts 0x00..0xFF then wraps to 0x00; B.ovf=1 at the end.

Source files
------------

// File: rtl/sync_up_counter_mod.sv
// Synchronous modulo-MODULUS up counter with enable, clear, parallel load,
// cascadable terminal count, sticky overflow and a load-range error pulse.
// Every flop is on clk; there are no derived or gated clocks.
module sync_up_counter_mod #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,       // synchronous, active low
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             load_err
);

   // Reject illegal parameterisations at elaboration time.
   generate
      if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 ||
          longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
         $error("sync_up_counter_mod: need 2 <= MODULUS <= 2**WIDTH (WIDTH=%0d MODULUS=%0d)",
                WIDTH, MODULUS);
      end
   endgenerate

   // Last count value before the wrap; equals all-ones when MODULUS == 2**WIDTH.
   localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             lerr_q, lerr_d;
   logic             at_max;

   assign at_max = (count_q == MAXQ);

   // Next state: clr > load > en > hold. load_err is a pulse, so it
   // defaults low and is only raised by an out-of-range load.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      lerr_d  = 1'b0;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         if (d > MAXQ) begin
            count_d = MAXQ;
            lerr_d  = 1'b1;
         end else begin
            count_d = d;
         end
      end else if (en) begin
         if (at_max) begin
            count_d = '0;
            ovf_d   = 1'b1;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   // State registers; reset overrides every other control input.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         lerr_q  <= lerr_d;
      end
   end

   // tc ignores load/clr so a downstream stage steps on the same edge as this one.
   assign tc       = at_max && en;
   assign q        = count_q;
   assign ovf      = ovf_q;
   assign load_err = lerr_q;

endmodule

// File: tb/tb_sync_up_counter_mod.sv
// Scoreboard bench: stimulus pushes the hand-computed post-edge state,
// an independent monitor pops and compares one entry after every edge.
module tb_sync_up_counter_mod;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT, MODULUS = 10
   logic       rst = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0;
   logic [3:0] d = '0;
   logic [3:0] q;
   logic       tc, ovf, load_err;

   sync_up_counter_mod #(.WIDTH(4), .MODULUS(10)) u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d),
      .q(q), .tc(tc), .ovf(ovf), .load_err(load_err));

   // Cascade pair, MODULUS = 16
   logic       c_rst = 1'b0, c_en = 1'b0;
   logic [3:0] a_q, b_q;
   logic       a_tc, b_tc, a_ovf, b_ovf, a_lerr, b_lerr;
   logic       c_zero = 1'b0;
   logic [3:0] c_d = '0;

   sync_up_counter_mod #(.WIDTH(4), .MODULUS(16)) u_a (
      .clk(clk), .rst(c_rst), .en(c_en), .clr(c_zero), .load(c_zero), .d(c_d),
      .q(a_q), .tc(a_tc), .ovf(a_ovf), .load_err(a_lerr));

   sync_up_counter_mod #(.WIDTH(4), .MODULUS(16)) u_b (
      .clk(clk), .rst(c_rst), .en(a_tc), .clr(c_zero), .load(c_zero), .d(c_d),
      .q(b_q), .tc(b_tc), .ovf(b_ovf), .load_err(b_lerr));

   typedef struct {
      bit         sel;    // 0: main DUT, 1: cascade
      logic [7:0] q;
      logic       ovf;
      logic       lerr;
      logic [1:0] tc;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Monitor: one comparison per edge whenever an expectation is pending.
   initial begin
      exp_t       e;
      logic [7:0] aq;
      logic       ao, al;
      logic [1:0] at;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) begin
               aq = {b_q, a_q}; ao = b_ovf; al = a_lerr | b_lerr; at = {a_tc, b_tc};
            end else begin
               aq = {4'h0, q};  ao = ovf;   al = load_err;       at = {1'b0, tc};
            end
            n_chk++;
            if (aq === e.q && ao === e.ovf && al === e.lerr && at === e.tc)
               n_pass++;
            else
               $display("FAIL %s: got q=%h ovf=%b lerr=%b tc=%b, want q=%h ovf=%b lerr=%b tc=%b",
                        e.name, aq, ao, al, at, e.q, e.ovf, e.lerr, e.tc);
         end
      end
   end

   // Drive one cycle of main-DUT inputs and record the state expected after the edge.
   task automatic step(input logic r, input logic c, input logic l, input logic e,
                       input logic [3:0] dv, input logic [3:0] eq, input logic eo,
                       input logic el, input logic et, input string nm);
      exp_t x;
      @(negedge clk);
      rst = r; clr = c; load = l; en = e; d = dv;
      x.sel = 1'b0; x.q = {4'h0, eq}; x.ovf = eo; x.lerr = el; x.tc = {1'b0, et}; x.name = nm;
      sb.push_back(x);
   endtask

   task automatic cstep(input logic r, input logic e, input logic [7:0] eq,
                        input logic eo, input logic [1:0] et, input string nm);
      exp_t x;
      @(negedge clk);
      c_rst = r; c_en = e;
      x.sel = 1'b1; x.q = eq; x.ovf = eo; x.lerr = 1'b0; x.tc = et; x.name = nm;
      sb.push_back(x);
   endtask

   initial begin
      //   rst clr ld en  d      q     ovf lerr tc
      // Reset, including reset beating a load and enable
      step(0, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0, "reset0");
      step(0, 0, 1, 1, 4'd5,  4'd0, 0, 0, 0, "reset1");
      // Count 1..9,0,1,2; wrap on edge 10
      for (int i = 1; i <= 12; i++)
         step(1, 0, 0, 1, 4'd0, 4'(i % 10), (i >= 10), 0, ((i % 10) == 9), $sformatf("count%0d", i));
      step(1, 0, 0, 1, 4'd0,  4'd3, 1, 0, 0, "cnt3");
      step(1, 0, 0, 1, 4'd0,  4'd4, 1, 0, 0, "cnt4");
      step(1, 0, 0, 1, 4'd0,  4'd5, 1, 0, 0, "cnt5");
      // Hold, then clear with en
      step(1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0, "hold1");
      step(1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0, "hold2");
      step(1, 0, 0, 0, 4'd0,  4'd5, 1, 0, 0, "hold3");
      step(1, 1, 0, 1, 4'd0,  4'd0, 0, 0, 0, "clr");
      // Legal and illegal loads
      step(1, 0, 1, 1, 4'd7,  4'd7, 0, 0, 0, "load7");
      step(1, 0, 1, 1, 4'd12, 4'd9, 0, 1, 1, "load12_sat");
      step(1, 0, 0, 1, 4'd0,  4'd0, 1, 0, 0, "wrap_after_sat");
      step(1, 0, 1, 0, 4'd15, 4'd9, 1, 1, 0, "bad_load_a");
      step(1, 0, 1, 0, 4'd10, 4'd9, 1, 1, 0, "bad_load_b");
      step(1, 0, 0, 0, 4'd0,  4'd9, 1, 0, 0, "lerr_drop");
      // Collisions at q=9: clear wins over load and wrap
      step(1, 1, 1, 1, 4'd3,  4'd0, 0, 0, 0, "clr_ld_wrap");
      step(1, 0, 1, 0, 4'd9,  4'd9, 0, 0, 0, "load9");
      step(1, 0, 0, 1, 4'd0,  4'd0, 1, 0, 0, "wrap2");
      step(1, 0, 1, 0, 4'd9,  4'd9, 1, 0, 0, "load9b");
      step(1, 0, 1, 1, 4'd9,  4'd9, 1, 0, 1, "ld_beats_wrap_tc");
      step(1, 0, 1, 1, 4'd3,  4'd3, 1, 0, 0, "ld3_ovf_kept");
      // Reset mid-count with load held
      step(1, 0, 0, 1, 4'd0,  4'd4, 1, 0, 0, "cnt4b");
      step(1, 0, 0, 1, 4'd0,  4'd5, 1, 0, 0, "cnt5b");
      step(1, 0, 0, 1, 4'd0,  4'd6, 1, 0, 0, "cnt6b");
      step(0, 0, 1, 1, 4'd12, 4'd0, 0, 0, 0, "mid_reset");
      step(1, 0, 0, 1, 4'd0,  4'd1, 0, 0, 0, "resume");

      // Cascade: {B,A} counts 0x00..0xFF, wraps to 0x00, B.ovf set at the end
      cstep(0, 0, 8'h00, 0, 2'b00, "c_reset");
      for (int i = 1; i <= 256; i++)
         cstep(1, 1, 8'(i), (i >= 256), {(i % 16) == 15, (i % 256) == 255},
               $sformatf("casc%0d", i));

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
